// File: rtl/fifo_pkg.sv
// Shared defaults and types for the async FIFO read-side blocks.
// The output-buffer depth limits bound the legal OBUF_DEPTH range (2..8).
package fifo_pkg;
   localparam int FIFO_DATA_SIZE = 8;
   localparam int FIFO_ADDR_SIZE = 4;
   localparam int OBUF_DEPTH_DEF = 3;
   localparam int OBUF_DEPTH_MIN = 2;
   localparam int OBUF_DEPTH_MAX = 8;

   typedef logic [FIFO_DATA_SIZE-1:0] data_t;

   function automatic int obuf_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/fifo_obuf_ring.sv
// Output ring buffer: storage, head/tail/count and push/pop bookkeeping.
// head_data is registered from the next-state view so it tracks mem[head] exactly.
module fifo_obuf_ring
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE  = FIFO_DATA_SIZE,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEF,
   localparam int CNT_W     = $clog2(OBUF_DEPTH + 1)
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] head_data,
   output logic [CNT_W-1:0]     count
);
   localparam int IDX_W = obuf_idx_w(OBUF_DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OBUF_DEPTH - 1);

   logic [DATA_SIZE-1:0] mem_r     [OBUF_DEPTH];
   logic [DATA_SIZE-1:0] mem_nxt_s [OBUF_DEPTH];
   logic [IDX_W-1:0]     head_r;
   logic [IDX_W-1:0]     tail_r;
   logic [IDX_W-1:0]     head_nxt_s;
   logic [IDX_W-1:0]     tail_nxt_s;
   logic [CNT_W-1:0]     count_r;
   logic [CNT_W-1:0]     count_nxt_s;
   logic [DATA_SIZE-1:0] head_data_r;
   logic                 pop_s;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      if (idx == IDX_LAST) begin
         return {IDX_W{1'b0}};
      end else begin
         return idx + IDX_W'(1);
      end
   endfunction

   // Next-state for storage, indices and occupancy; a pop on an empty ring is ignored.
   always_comb begin
      pop_s     = pop && (count_r != {CNT_W{1'b0}});
      mem_nxt_s = mem_r;
      if (push) begin
         mem_nxt_s[tail_r] = push_data;
         tail_nxt_s        = idx_inc(tail_r);
      end else begin
         tail_nxt_s = tail_r;
      end
      if (pop_s) begin
         head_nxt_s = idx_inc(head_r);
      end else begin
         head_nxt_s = head_r;
      end
      count_nxt_s = count_r + CNT_W'(push) - CNT_W'(pop_s);
   end

   // Ring state registers, cleared asynchronously.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         for (int i = 0; i < OBUF_DEPTH; i++) begin
            mem_r[i] <= {DATA_SIZE{1'b0}};
         end
         head_r      <= {IDX_W{1'b0}};
         tail_r      <= {IDX_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         head_data_r <= {DATA_SIZE{1'b0}};
      end else begin
         mem_r       <= mem_nxt_s;
         head_r      <= head_nxt_s;
         tail_r      <= tail_nxt_s;
         count_r     <= count_nxt_s;
         head_data_r <= mem_nxt_s[head_nxt_s];
      end
   end

   assign head_data = head_data_r;
   assign count     = count_r;
endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: issues credit-limited rinc, captures the
// memory's registered read data and presents it as a first-word-fall-through stream.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE  = FIFO_DATA_SIZE,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEF,
   localparam int CNT_W     = $clog2(OBUF_DEPTH + 1)
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 rempty,
   output logic                 rinc,
   input  logic [DATA_SIZE-1:0] rdata,
   output logic                 m_valid,
   output logic [DATA_SIZE-1:0] m_data,
   input  logic                 m_ready,
   output logic [CNT_W-1:0]     occupancy
);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(OBUF_DEPTH);

   logic [CNT_W-1:0]     count_s;
   logic [CNT_W:0]       credit_s;
   logic [DATA_SIZE-1:0] head_data_s;
   logic                 rinc_s;
   logic                 f_r;
   logic                 valid_s;
   logic                 pop_s;

   // A read is requested only when the ring plus the word in flight leaves a free slot,
   // so m_ready never reaches rinc combinationally.
   always_comb begin
      credit_s = {1'b0, count_s} + {{CNT_W{1'b0}}, f_r};
      if (rrst_n && !rempty && (credit_s < DEPTH_C)) begin
         rinc_s = 1'b1;
      end else begin
         rinc_s = 1'b0;
      end
      valid_s = (count_s != {CNT_W{1'b0}});
      pop_s   = valid_s && m_ready;
   end

   // In-flight flag: rdata carries a word in the cycle after an issued rinc.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         f_r <= 1'b0;
      end else begin
         f_r <= rinc_s;
      end
   end

   fifo_obuf_ring #(
      .DATA_SIZE  (DATA_SIZE),
      .OBUF_DEPTH (OBUF_DEPTH)
   ) u_ring (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .push      (f_r),
      .push_data (rdata),
      .pop       (pop_s),
      .head_data (head_data_s),
      .count     (count_s)
   );

   assign rinc      = rinc_s;
   assign m_valid   = valid_s;
   assign m_data    = head_data_s;
   assign occupancy = count_s;
endmodule
